// File: rtl/bank_access_ctrl_if.sv
// Bus bundle for bank_access_ctrl: AGU index vectors in, bank SRAM strobes and data, reordered lane data out.
// Lane address/bank field widths come from `MA_width / `BANK_width (defaults below if not predefined).
`ifndef MA_width
`define MA_width 10
`endif
`ifndef BANK_width
`define BANK_width 5
`endif

interface bank_access_ctrl_if #(
    parameter int DATA_W = 64
);
    logic                      LAST_STAGE;
    logic                      BN_MA_out_en;
    logic                      AGU_done_out;
    logic [16*`MA_width-1:0]   MA_idx_bus;
    logic [16*`BANK_width-1:0] BN_idx_bus;
    logic [15:0]               bank_rd_en;
    logic [16*`MA_width-1:0]   bank_addr_bus;
    logic [16*DATA_W-1:0]      bank_rdata_bus;
    logic [16*DATA_W-1:0]      lane_rdata_bus;
    logic                      lane_rvalid;
    logic [15:0]               lane_mask;
    logic                      dispatch_done;
    logic                      conflict_err;
    logic [15:0]               vec_cnt;

    modport master (
        output LAST_STAGE, BN_MA_out_en, AGU_done_out, MA_idx_bus, BN_idx_bus, bank_rdata_bus,
        input  bank_rd_en, bank_addr_bus, lane_rdata_bus, lane_rvalid, lane_mask,
               dispatch_done, conflict_err, vec_cnt
    );

    modport slave (
        input  LAST_STAGE, BN_MA_out_en, AGU_done_out, MA_idx_bus, BN_idx_bus, bank_rdata_bus,
        output bank_rd_en, bank_addr_bus, lane_rdata_bus, lane_rvalid, lane_mask,
               dispatch_done, conflict_err, vec_cnt
    );
endinterface

// File: rtl/bank_access_ctrl.sv
// Scatters a 16-lane index vector onto 16 SRAM banks and gathers the read data back into lane order.
// Optional macro BANK_CONFLICT_CHECK_EN adds a sticky duplicate-bank / bad-index detector.
module bank_access_ctrl #(
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    bank_access_ctrl_if.slave bus
);
    localparam int MAW = `MA_width;
    localparam int BW  = `BANK_width;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t state_q, state_d;
    logic   accept;
    logic   dispatch_done;
    logic   in_flight;

    logic [15:0]          mask_in;
    logic [15:0]          rd_en_d, rd_en_q;
    logic [16*MAW-1:0]    addr_d, addr_q;
    logic [16*DATA_W-1:0] lane_rdata_d, lane_rdata_q;
    logic                 lane_rvalid_d, lane_rvalid_q;
    logic [15:0]          lane_mask_d, lane_mask_q;
    logic [15:0]          vec_cnt_d, vec_cnt_q;

    // delay line: entry k is stage p(k), carrying BN list and mask alongside the bank read
    logic [RD_LAT:0]      dl_vld_d, dl_vld_q;
    logic [16*BW-1:0]     dl_bn_d   [RD_LAT+1];
    logic [16*BW-1:0]     dl_bn_q   [RD_LAT+1];
    logic [15:0]          dl_mask_d [RD_LAT+1];
    logic [15:0]          dl_mask_q [RD_LAT+1];

    assign mask_in   = bus.LAST_STAGE ? 16'h0003 : 16'hFFFF;
    assign in_flight = |dl_vld_q;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = bus.AGU_done_out ? DRAIN : RUN;
            RUN:   if (bus.AGU_done_out) state_d = DRAIN;
            DRAIN: if (!in_flight) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        accept        = bus.BN_MA_out_en && ((state_q == IDLE) || (state_q == RUN));
        dispatch_done = (state_q == DONE);
    end

    // stage p0 -> p1: scatter lanes onto banks; descending scan lets the lowest lane win
    always_comb begin
        logic [BW-1:0] bn;
        bn      = '0;
        rd_en_d = '0;
        addr_d  = '0;
        if (accept) begin
            for (int i = 15; i >= 0; i--) begin
                bn = bus.BN_idx_bus[i*BW +: BW];
                if (mask_in[i] && (int'(bn) < 16)) begin
                    rd_en_d[bn[3:0]]              = 1'b1;
                    addr_d[bn[3:0]*MAW +: MAW]    = bus.MA_idx_bus[i*MAW +: MAW];
                end
            end
        end
    end

    always_comb begin
        dl_vld_d     = {dl_vld_q[RD_LAT-1:0], accept};
        dl_bn_d[0]   = bus.BN_idx_bus;
        dl_mask_d[0] = mask_in;
        for (int k = 1; k <= RD_LAT; k++) begin
            dl_bn_d[k]   = dl_bn_q[k-1];
            dl_mask_d[k] = dl_mask_q[k-1];
        end
    end

    // stage p(RD_LAT) -> output: gather bank data back into lane order
    always_comb begin
        logic [BW-1:0] bn;
        bn            = '0;
        lane_rdata_d  = '0;
        lane_mask_d   = '0;
        lane_rvalid_d = dl_vld_q[RD_LAT];
        if (dl_vld_q[RD_LAT]) begin
            lane_mask_d = dl_mask_q[RD_LAT];
            for (int i = 0; i < 16; i++) begin
                bn = dl_bn_q[RD_LAT][i*BW +: BW];
                if (dl_mask_q[RD_LAT][i] && (int'(bn) < 16))
                    lane_rdata_d[i*DATA_W +: DATA_W] = bus.bank_rdata_bus[bn[3:0]*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        vec_cnt_d = vec_cnt_q;
        if (accept) vec_cnt_d = (state_q == IDLE) ? 16'd1 : sat_inc(vec_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q       <= '0;
            addr_q        <= '0;
            lane_rdata_q  <= '0;
            lane_rvalid_q <= 1'b0;
            lane_mask_q   <= '0;
            vec_cnt_q     <= '0;
            dl_vld_q      <= '0;
        end else begin
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            lane_rdata_q  <= lane_rdata_d;
            lane_rvalid_q <= lane_rvalid_d;
            lane_mask_q   <= lane_mask_d;
            vec_cnt_q     <= vec_cnt_d;
            dl_vld_q      <= dl_vld_d;
        end
    end

    // payload of the delay line is qualified by dl_vld_q, so it needs no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k <= RD_LAT; k++) begin
            dl_bn_q[k]   <= dl_bn_d[k];
            dl_mask_q[k] <= dl_mask_d[k];
        end
    end

`ifdef BANK_CONFLICT_CHECK_EN
    logic conflict_hit;
    logic conflict_d, conflict_q;

    always_comb begin
        logic [BW-1:0] bn;
        logic [15:0]   seen;
        bn           = '0;
        seen         = '0;
        conflict_hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bn = bus.BN_idx_bus[i*BW +: BW];
            if (mask_in[i]) begin
                if (int'(bn) > 15) begin
                    conflict_hit = 1'b1;
                end else begin
                    if (seen[bn[3:0]]) conflict_hit = 1'b1;
                    seen[bn[3:0]] = 1'b1;
                end
            end
        end
        conflict_d = conflict_q | (accept & conflict_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) conflict_q <= 1'b0;
        else     conflict_q <= conflict_d;
    end

    assign bus.conflict_err = conflict_q;
`else
    assign bus.conflict_err = 1'b0;
`endif

    assign bus.bank_rd_en     = rd_en_q;
    assign bus.bank_addr_bus  = addr_q;
    assign bus.lane_rdata_bus = lane_rdata_q;
    assign bus.lane_rvalid    = lane_rvalid_q;
    assign bus.lane_mask      = lane_mask_q;
    assign bus.dispatch_done  = dispatch_done;
    assign bus.vec_cnt        = vec_cnt_q;
endmodule

// File: tb/tb_bank_access_ctrl.sv
// Scoreboard bench for bank_access_ctrl: a bank SRAM model with RD_LAT latency feeds the DUT,
// expected lane vectors are queued at issue and compared when lane_rvalid appears.
`timescale 1ns/1ps
`ifndef MA_width
`define MA_width 10
`endif
`ifndef BANK_width
`define BANK_width 5
`endif

module tb_bank_access_ctrl;
    localparam int DW  = 32;
    localparam int RL  = 1;
    localparam int MAW = `MA_width;
    localparam int BW  = `BANK_width;
`ifdef BANK_CONFLICT_CHECK_EN
    localparam logic CC = 1'b1;
`else
    localparam logic CC = 1'b0;
`endif

    typedef struct {
        logic [15:0]      mask;
        logic [16*DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_rv_cyc = 0;
    int   rv_run = 0;
    logic prev_rv = 1'b0;
    bit   mix = 1'b0;
    exp_t sb[$];

    logic [BW-1:0]  bn_v [16];
    logic [MAW-1:0] ma_v [16];

    logic [15:0]       pen [RL];
    logic [16*MAW-1:0] pad [RL];

    bank_access_ctrl_if #(.DATA_W(DW)) bus ();

    bank_access_ctrl #(.DATA_W(DW), .RD_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bank_val(input int b, input logic [MAW-1:0] a, input bit mx);
        return mx ? DW'(100 + b + (int'(a) << 8)) : DW'(100 + b);
    endfunction

    // bank SRAM model: data appears RL cycles after the strobe
    always @(posedge clk) begin
        pen[0] <= bus.bank_rd_en;
        pad[0] <= bus.bank_addr_bus;
        for (int k = 1; k < RL; k++) begin
            pen[k] <= pen[k-1];
            pad[k] <= pad[k-1];
        end
    end

    always_comb begin
        bus.bank_rdata_bus = '0;
        for (int b = 0; b < 16; b++)
            bus.bank_rdata_bus[b*DW +: DW] = pen[RL-1][b] ? bank_val(b, pad[RL-1][b*MAW +: MAW], mix)
                                                          : DW'(32'hDEAD0000 + b);
    end

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic ls, output logic [15:0] m, output logic [15:0] en,
                                  output logic [16*MAW-1:0] ad, output logic [16*DW-1:0] ld);
        int b;
        m  = ls ? 16'h0003 : 16'hFFFF;
        en = '0;
        ad = '0;
        ld = '0;
        for (int i = 0; i < 16; i++) begin
            b = int'(bn_v[i]);
            if (m[i] && b < 16 && !en[b]) begin
                en[b] = 1'b1;
                ad[b*MAW +: MAW] = ma_v[i];
            end
        end
        for (int i = 0; i < 16; i++) begin
            b = int'(bn_v[i]);
            if (m[i] && b < 16) ld[i*DW +: DW] = bank_val(b, ad[b*MAW +: MAW], mix);
        end
    endfunction

    // called at a negedge; returns at the following negedge
    task automatic send(input logic ls, input logic last, input logic acc);
        logic [15:0]       m, en;
        logic [16*MAW-1:0] ad;
        logic [16*DW-1:0]  ld;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            bus.BN_idx_bus[i*BW +: BW]  = bn_v[i];
            bus.MA_idx_bus[i*MAW +: MAW] = ma_v[i];
        end
        bus.LAST_STAGE   = ls;
        bus.BN_MA_out_en = 1'b1;
        bus.AGU_done_out = last;
        model(ls, m, en, ad, ld);
        if (acc) begin
            e.mask = m;
            e.data = ld;
            sb.push_back(e);
        end else begin
            en = '0;
            ad = '0;
        end
        @(posedge clk);
        #1;
        bus.BN_MA_out_en = 1'b0;
        bus.AGU_done_out = 1'b0;
        check_eq("bank_rd_en", 512'(bus.bank_rd_en), 512'(en));
        check_eq("bank_addr", 512'(bus.bank_addr_bus), 512'(ad));
        @(negedge clk);
    endtask

    task automatic wait_done(input int run_len, input int cnt);
        int n;
        n = 0;
        while (!bus.dispatch_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.dispatch_done) begin
            check_eq("done_timeout", 0, 1);
        end else begin
            check_eq("done_latency", 512'(cyc - last_rv_cyc), 1);
            check_eq("rvalid_run", 512'(rv_run), 512'(run_len));
            check_eq("vec_cnt", 512'(bus.vec_cnt), 512'(cnt));
        end
        @(negedge clk);
        check_eq("done_pulse", 512'(bus.dispatch_done), 0);
        check_eq("vec_cnt_idle", 512'(bus.vec_cnt), 512'(cnt));
    endtask

    // output monitor: pop the scoreboard on each valid lane vector
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.lane_rvalid) begin
                rv_run      = prev_rv ? rv_run + 1 : 1;
                last_rv_cyc = cyc;
                if (sb.size() == 0) begin
                    check_eq("spurious_rvalid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("lane_mask", 512'(bus.lane_mask), 512'(e.mask));
                    check_eq("lane_rdata", 512'(bus.lane_rdata_bus), 512'(e.data));
                end
            end
            prev_rv = bus.lane_rvalid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic perm(input int k, input int v);
        for (int i = 0; i < 16; i++) begin
            bn_v[i] = BW'((i * k + v) % 16);
            ma_v[i] = MAW'($urandom_range(0, (1 << MAW) - 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, 512'(bus.bank_rd_en), 0);
        check_eq({tag, "_addr"}, 512'(bus.bank_addr_bus), 0);
        check_eq({tag, "_rdata"}, 512'(bus.lane_rdata_bus), 0);
        check_eq({tag, "_rvalid"}, 512'(bus.lane_rvalid), 0);
        check_eq({tag, "_mask"}, 512'(bus.lane_mask), 0);
        check_eq({tag, "_done"}, 512'(bus.dispatch_done), 0);
        check_eq({tag, "_conflict"}, 512'(bus.conflict_err), 0);
        check_eq({tag, "_vec_cnt"}, 512'(bus.vec_cnt), 0);
    endtask

    initial begin
        bus.LAST_STAGE   = 1'b0;
        bus.BN_MA_out_en = 1'b0;
        bus.AGU_done_out = 1'b0;
        bus.MA_idx_bus   = '0;
        bus.BN_idx_bus   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // reversed bank map, constant bank data 100+b -> lane i sees 115-i
        mix = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bn_v[i] = BW'(15 - i);
            ma_v[i] = MAW'(i);
        end
        send(1'b0, 1'b1, 1'b1);
        wait_done(1, 1);

        // last stage: only lanes 0..1, everything else must stay quiet
        mix = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bn_v[i] = BW'($urandom_range(0, 31));
            ma_v[i] = MAW'($urandom_range(0, (1 << MAW) - 1));
        end
        bn_v[0] = 3; bn_v[1] = 9; ma_v[0] = 5; ma_v[1] = 7;
        send(1'b1, 1'b1, 1'b1);
        wait_done(1, 1);

        // four back-to-back vectors, done on the 4th
        for (int v = 0; v < 4; v++) begin
            perm(2 * v + 3, v * 5);
            send(1'b0, v == 3, 1'b1);
        end
        wait_done(4, 4);
        check_eq("conflict_clean", 512'(bus.conflict_err), 0);

        // vector offered during DRAIN is ignored
        perm(5, 1);
        send(1'b0, 1'b0, 1'b1);
        perm(7, 2);
        send(1'b0, 1'b1, 1'b1);
        perm(3, 9);
        send(1'b0, 1'b0, 1'b0);
        wait_done(2, 2);

        // lanes 2 and 7 share bank 5; bank 5 must take lane 2's address
        for (int i = 0; i < 16; i++) begin
            bn_v[i] = BW'(i);
            ma_v[i] = MAW'(40 + i);
        end
        bn_v[2] = 5; bn_v[5] = 2; bn_v[7] = 5;
        send(1'b0, 1'b1, 1'b1);
        wait_done(1, 1);
        check_eq("conflict_err", 512'(bus.conflict_err), 512'(CC));

        // out-of-range bank on lane 4 is dropped and its lane reads 0
        for (int i = 0; i < 16; i++) begin
            bn_v[i] = BW'(i);
            ma_v[i] = MAW'(200 + i);
        end
        bn_v[4] = 20;
        send(1'b0, 1'b1, 1'b1);
        wait_done(1, 1);
        check_eq("conflict_sticky", 512'(bus.conflict_err), 512'(CC));

        // reset one cycle after acceptance discards the in-flight vector
        perm(3, 4);
        send(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("post_reset_vec_cnt", 512'(bus.vec_cnt), 0);

        // controller is back in IDLE: a new one-vector stage runs normally
        perm(11, 6);
        send(1'b0, 1'b1, 1'b1);
        wait_done(1, 1);

        check_eq("scoreboard_empty", 512'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
